// File: rtl/notch_filter_if.sv
// -----------------------------------------------------------------------------
// notch_filter_if
//   Sample/coefficient bundle for one biquad stage.
//
//   Signals (width = sample/coefficient word width, Q2.(width-2)):
//     EN            clock enable: 1 = process one sample this cycle
//     bypass        1 = pass x_n straight through to y_n
//     filter_coeff  packed {b0, b1, b2, a1, a2}, b0 in the top word
//     x_n           input sample
//     y_n           registered output sample
//
//   master: the side that supplies samples and coefficients.
//   slave : the filter itself.
// -----------------------------------------------------------------------------
interface notch_filter_if #(
    parameter int width = 16
);
    logic                      EN;
    logic                      bypass;
    logic        [5*width-1:0] filter_coeff;
    logic signed [width-1:0]   x_n;
    logic signed [width-1:0]   y_n;

    modport master (
        output EN,
        output bypass,
        output filter_coeff,
        output x_n,
        input  y_n
    );

    modport slave (
        input  EN,
        input  bypass,
        input  filter_coeff,
        input  x_n,
        output y_n
    );
endinterface

// File: rtl/notch_filter.sv
// -----------------------------------------------------------------------------
// notch_filter
//   Direct Form I biquad, one sample per enabled clock:
//     acc  = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]
//     y[n] = sat( acc >>> (width-2) )
//   Coefficients and samples are Q2.(width-2). a1/a2 are used as stored,
//   i.e. the denominator is 1 + a1 z^-1 + a2 z^-2. Output is registered
//   (one-cycle latency) and the output format equals the input format, so
//   stages cascade directly.
//
//   Ports:
//     CLK    sole clock, rising edge
//     rst_n  synchronous reset, active HIGH despite the name; clears output
//            and all delay registers, takes priority over EN
//     bus    notch_filter_if.slave: EN, bypass, filter_coeff, x_n, y_n
// -----------------------------------------------------------------------------
module notch_filter #(
    parameter int width = 16
) (
    input logic           CLK,
    input logic           rst_n,
    notch_filter_if.slave bus
);

    // Three guard bits cover the sum of five full-width products.
    localparam int ACC_W = 2 * width + 3;

    typedef logic signed [width-1:0]   sample_t;
    typedef logic signed [2*width-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]   acc_t;

    // Saturation bounds expressed at accumulator width after the shift.
    localparam acc_t SAT_MAX = {{(ACC_W-width+1){1'b0}}, {(width-1){1'b1}}};
    localparam acc_t SAT_MIN = {{(ACC_W-width+1){1'b1}}, {(width-1){1'b0}}};

    // Full signed product: operands are sign-extended to the result width
    // first so the multiply never wraps.
    function automatic prod_t mul(input sample_t a, input sample_t b);
        prod_t ae;
        prod_t be;
        ae = prod_t'(a);
        be = prod_t'(b);
        return ae * be;
    endfunction

    function automatic acc_t ext(input prod_t p);
        return acc_t'(p);
    endfunction

    // Coefficient words, sampled combinationally every cycle.
    sample_t b0, b1, b2, a1, a2;
    assign b0 = bus.filter_coeff[5*width-1:4*width];
    assign b1 = bus.filter_coeff[4*width-1:3*width];
    assign b2 = bus.filter_coeff[3*width-1:2*width];
    assign a1 = bus.filter_coeff[2*width-1:width];
    assign a2 = bus.filter_coeff[width-1:0];

    // Delay lines. y[n-1] always equals the value on y_n, so the output
    // register and the first y tap are one and the same flop.
    sample_t x1_q, x1_d;
    sample_t x2_q, x2_d;
    sample_t y1_q, y1_d;
    sample_t y2_q, y2_d;

    acc_t    acc;
    acc_t    shifted;
    sample_t y_filt;
    sample_t y_in;

    always_comb begin
        acc = ext(mul(b0, bus.x_n))
            + ext(mul(b1, x1_q))
            + ext(mul(b2, x2_q))
            - ext(mul(a1, y1_q))
            - ext(mul(a2, y2_q));

        // Arithmetic shift drops the Q(width-2) fraction, rounding toward -inf.
        shifted = acc >>> (width - 2);

        if (shifted > SAT_MAX) begin
            y_filt = SAT_MAX[width-1:0];
        end else if (shifted < SAT_MIN) begin
            y_filt = SAT_MIN[width-1:0];
        end else begin
            y_filt = shifted[width-1:0];
        end
    end

    // In bypass the y taps are fed with the raw input as well, so leaving
    // bypass continues from history that matches what was actually output.
    assign y_in = bus.bypass ? bus.x_n : y_filt;

    always_comb begin
        // NOTE: every combinational output gets a hold default first so no
        // path leaves it unassigned and no latch is inferred.
        x1_d = x1_q;
        x2_d = x2_q;
        y1_d = y1_q;
        y2_d = y2_q;
        if (bus.EN) begin
            x1_d = bus.x_n;
            x2_d = x1_q;
            y1_d = y_in;
            y2_d = y1_q;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every tap samples the pre-edge
        // value of its neighbour and the delay lines shift correctly.
        if (rst_n) begin
            x1_q <= '0;
            x2_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
        end else begin
            x1_q <= x1_d;
            x2_q <= x2_d;
            y1_q <= y1_d;
            y2_q <= y2_d;
        end
    end

    assign bus.y_n = y1_q;

endmodule

// File: tb/tb_notch_filter.sv
// -----------------------------------------------------------------------------
// tb_notch_filter
//   Two notch_filter stages in cascade (stage 1 y_n drives stage 2 x_n).
//   A behavioural biquad model computes expected outputs for both stages;
//   each expected sample is queued when stimulus is applied and compared
//   once the DUT has clocked.
// -----------------------------------------------------------------------------
module tb_notch_filter;

    localparam int W = 16;

    localparam logic [79:0] C_IDENT  = {16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    localparam logic [79:0] C_NOTCH1 = {16'h4000, 16'h678E, 16'h4000, 16'h6473, 16'h3C38};
    localparam logic [79:0] C_NOTCH2 = {16'h4000, 16'hC000, 16'h4000, 16'hC1EC, 16'h3C38};
    localparam logic [79:0] C_SAT    = {16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000};

    logic CLK = 1'b0;
    logic rst_n;

    notch_filter_if #(.width(W)) bus1 ();
    notch_filter_if #(.width(W)) bus2 ();

    notch_filter #(.width(W)) u_dut1 (.CLK(CLK), .rst_n(rst_n), .bus(bus1.slave));
    notch_filter #(.width(W)) u_dut2 (.CLK(CLK), .rst_n(rst_n), .bus(bus2.slave));

    assign bus2.EN     = bus1.EN;
    assign bus2.bypass = bus1.bypass;
    assign bus2.x_n    = bus1.y_n;

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    // Model state per stage: output and the four taps.
    logic signed [15:0] m_y [2];
    logic signed [15:0] m_x1[2];
    logic signed [15:0] m_x2[2];
    logic signed [15:0] m_y1[2];
    logic signed [15:0] m_y2[2];

    logic [79:0] coeff1;
    logic [79:0] coeff2;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic signed [15:0] biquad(
        input logic [79:0] c, input logic signed [15:0] x,
        input logic signed [15:0] x1, input logic signed [15:0] x2,
        input logic signed [15:0] y1, input logic signed [15:0] y2);
        longint acc;
        longint b0, b1, b2, a1, a2;
        b0  = longint'($signed(c[79:64]));
        b1  = longint'($signed(c[63:48]));
        b2  = longint'($signed(c[47:32]));
        a1  = longint'($signed(c[31:16]));
        a2  = longint'($signed(c[15:0]));
        acc = b0 * longint'(x) + b1 * longint'(x1) + b2 * longint'(x2)
            - a1 * longint'(y1) - a2 * longint'(y2);
        acc = acc >>> 14;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc[15:0];
    endfunction

    task automatic model_step(input int f, input logic signed [15:0] x, input bit en,
                              input bit byp, input bit rst, input logic [79:0] c);
        logic signed [15:0] yn;
        if (rst) begin
            m_y[f] = '0; m_x1[f] = '0; m_x2[f] = '0; m_y1[f] = '0; m_y2[f] = '0;
        end else if (en) begin
            yn = byp ? x : biquad(c, x, m_x1[f], m_x2[f], m_y1[f], m_y2[f]);
            m_x2[f] = m_x1[f];
            m_x1[f] = x;
            m_y2[f] = m_y1[f];
            m_y1[f] = yn;
            m_y[f]  = yn;
        end
    endtask

    // Apply one cycle of stimulus, queue expectations, clock, compare.
    task automatic step(input string tag, input logic [15:0] x, input bit en,
                        input bit byp, input bit rst);
        logic signed [15:0] stage2_in;
        @(negedge CLK);
        bus1.x_n          = x;
        bus1.EN           = en;
        bus1.bypass       = byp;
        bus1.filter_coeff = coeff1;
        bus2.filter_coeff = coeff2;
        rst_n             = rst;
        stage2_in = m_y[0];
        model_step(0, x, en, byp, rst, coeff1);
        exp_q0.push_back(m_y[0]);
        model_step(1, stage2_in, en, byp, rst, coeff2);
        exp_q1.push_back(m_y[1]);
        @(posedge CLK);
        #1;
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            check(tag, bus1.y_n, exp_q0.pop_front());
            check({tag, "/stage2"}, bus2.y_n, exp_q1.pop_front());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] xs;
        logic [31:0] r;
        logic [15:0] ident_x[3];

        for (int f = 0; f < 2; f++) begin
            m_y[f] = '0; m_x1[f] = '0; m_x2[f] = '0; m_y1[f] = '0; m_y2[f] = '0;
        end
        coeff1            = C_IDENT;
        coeff2            = C_NOTCH2;
        rst_n             = 1'b1;
        bus1.EN           = 1'b0;
        bus1.bypass       = 1'b0;
        bus1.x_n          = '0;
        bus1.filter_coeff = coeff1;
        bus2.filter_coeff = coeff2;

        // Reset with EN low still clears, output stays 0 until first enabled edge.
        step("reset", 16'h5555, 1'b0, 1'b0, 1'b1);
        check("reset_y0", bus1.y_n, 16'h0000);
        step("reset", 16'h5555, 1'b1, 1'b1, 1'b1);
        check("reset_y1", bus1.y_n, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            step("post_reset_idle", 16'h7777, 1'b0, 1'b0, 1'b0);
            check("post_reset_hold", bus1.y_n, 16'h0000);
        end

        // Identity: output equals input one cycle later.
        ident_x[0] = 16'h1234; ident_x[1] = 16'hF000; ident_x[2] = 16'h7FFF;
        for (int i = 0; i < 3; i++) begin
            step("identity", ident_x[i], 1'b1, 1'b0, 1'b0);
            check("identity_exact", bus1.y_n, ident_x[i]);
        end

        // Impulse response of the notch from zero state.
        coeff1 = C_NOTCH1;
        step("impulse_rst", 16'h0000, 1'b1, 1'b0, 1'b1);
        step("impulse", 16'h1000, 1'b1, 1'b0, 1'b0);
        check("impulse_y0", bus1.y_n, 16'h1000);
        step("impulse", 16'h0000, 1'b1, 1'b0, 1'b0);
        check("impulse_y1", bus1.y_n, 16'h00C6);
        for (int i = 0; i < 20; i++) step("impulse_tail", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Reset in the tail, then a fresh impulse must match the first one.
        step("mid_reset", 16'h0000, 1'b1, 1'b0, 1'b1);
        check("mid_reset_y", bus1.y_n, 16'h0000);
        step("impulse2", 16'h1000, 1'b1, 1'b0, 1'b0);
        check("impulse2_y0", bus1.y_n, 16'h1000);
        step("impulse2", 16'h0000, 1'b1, 1'b0, 1'b0);
        check("impulse2_y1", bus1.y_n, 16'h00C6);
        for (int i = 0; i < 10; i++) step("impulse2_tail", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Enable freeze mid-stream: inputs during the freeze are ignored.
        for (int i = 0; i < 6; i++) begin
            r = $urandom;
            step("pre_freeze", r[15:0], 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            r = $urandom;
            step("freeze", r[15:0], 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            r = $urandom;
            step("post_freeze", r[15:0], 1'b1, 1'b0, 1'b0);
        end

        // Bypass: y_n follows x_n one cycle late; then resume filtering.
        for (int i = 0; i < 5; i++) begin
            r  = $urandom;
            xs = r[15:0];
            step("bypass", xs, 1'b1, 1'b1, 1'b0);
            check("bypass_exact", bus1.y_n, xs);
        end
        for (int i = 0; i < 6; i++) begin
            r = $urandom;
            step("post_bypass", r[15:0], 1'b1, 1'b0, 1'b0);
        end

        // Saturation at both rails.
        coeff1 = C_SAT;
        step("sat_rst", 16'h0000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step("sat_pos", 16'h7FFF, 1'b1, 1'b0, 1'b0);
        check("sat_pos_rail", bus1.y_n, 16'h7FFF);
        for (int i = 0; i < 4; i++) step("sat_neg", 16'h8000, 1'b1, 1'b0, 1'b0);
        check("sat_neg_rail", bus1.y_n, 16'h8000);

        // Cascade over a long mixed-amplitude stream.
        coeff1 = C_NOTCH1;
        coeff2 = C_NOTCH2;
        step("cascade_rst", 16'h0000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6712; i++) begin
            r  = $urandom;
            xs = 16'($signed(r[15:0]) >>> (i % 4));
            step("cascade", xs, 1'b1, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/notch_filter.md
NOTCH_FILTER -- requirements
Module: notch_filter

Interface
REQ-001 Parameter: width, default 16, sample and coefficient word width in bits; coefficients and samples use 2 integer bits (incl. sign) and width-2 fraction bits (Q2.14 at default).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-high: a 1 sampled on a CLK rising edge resets the block.
REQ-004 EN  input  1  clock enable; 1 = process one sample per cycle, 0 = freeze all state.
REQ-005 bypass  input  1  1 = pass x_n to y_n unfiltered with the same one-cycle latency.
REQ-006 filter_coeff  input  5*width  packed signed coefficients: [5w-1:4w]=b0, [4w-1:3w]=b1, [3w-1:2w]=b2, [2w-1:w]=a1, [w-1:0]=a2.
REQ-007 x_n  input  width  signed input sample, Q2.14.
REQ-008 y_n  output  width  signed registered output sample, Q2.14.

Function
REQ-009 The block SHALL implement a Direct Form I biquad: acc = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2].
REQ-010 Stored a1/a2 SHALL be used as given (denominator 1 + a1 z^-1 + a2 z^-2); no sign inversion of the coefficient words.
REQ-011 Each product SHALL be a full 2*width signed product (Q4.28); the accumulator SHALL be at least 2*width+3 bits so no intermediate overflow occurs.
REQ-012 The result SHALL be acc arithmetically shifted right by width-2 (truncation toward minus infinity), then saturated to [-2^(width-1), 2^(width-1)-1].
REQ-013 y_n SHALL be registered: the value computed from x_n sampled at edge k appears on y_n immediately after edge k and is held until the next enabled edge (one-cycle latency).
REQ-014 x[n-1], x[n-2] SHALL be delay registers of x_n; y[n-1], y[n-2] SHALL be delay registers of the saturated output (the value driven on y_n).
REQ-015 When EN=0 on an edge, y_n and all four delay registers SHALL hold their values; x_n is ignored.
REQ-016 When EN=1 and bypass=1, y_n SHALL load x_n; the x delay line SHALL shift in x_n and the y delay line SHALL shift in x_n, so leaving bypass resumes without a transient from stale state.
REQ-017 filter_coeff SHALL be sampled combinationally each cycle; a coefficient change takes effect on the next enabled edge with no reset of state.
REQ-018 Coefficient 0x4000 (default width) SHALL represent +1.0, 0xC000 -1.0; b0=0x4000 with all other coefficients 0 SHALL give y_n = x_n delayed one cycle, bit-exact.
REQ-019 Two instances SHALL cascade directly (y_n of one to x_n of the next) with no format conversion.

Reset
REQ-020 On a rising edge with rst_n=1, y_n and all four delay registers SHALL become 0, regardless of EN and bypass.
REQ-021 Reset SHALL take priority over EN; reset asserted mid-stream SHALL discard all history, and the first enabled edge after reset computes from zero state.
REQ-022 After reset release, y_n SHALL remain 0 until the first enabled edge.

Verification
REQ-023 Identity: coeff {4000,0000,0000,0000,0000}, x stream 0x1234,0xF000,0x7FFF -> y_n same values one cycle later.
REQ-024 Impulse: coeff {4000,678E,4000,6473,3C38}, x=0x1000 then 0 -> y sequence 0x1000, 0x00C6, then values matching a bit-exact model of REQ-009..REQ-014.
REQ-025 Saturation: coeff {7FFF,7FFF,0,0,0}, x=0x7FFF held -> y_n=0x7FFF; x=0x8000 held -> y_n=0x8000.
REQ-026 Enable/bypass: EN=0 for 5 cycles mid-stream -> y_n and state frozen, resumes exactly; bypass=1 -> y_n = x_n delayed one cycle.
REQ-027 Reset mid-stream: rst_n=1 for one edge during the impulse tail -> y_n=0 next cycle, and the response to a fresh impulse equals REQ-024.
REQ-028 Cascade: notch {4000,678E,4000,6473,3C38} into notch {4000,C000,4000,C1EC,3C38} over a 6712-sample stream -> zero mismatches against the bit-exact model.
